memwb_pipe_stage: RTL

- Parametrised MEM/WB pipeline stage; successor to the fixed-width 32-bit MEM/WB register.
- Adds the following to the fixed register:
  - valid/ready handshake on both sides
  - 2-entry skid buffer, so upstream never sees a combinational ready path
  - synchronous flush
  - writeback-data mux
  - x0 write suppression
  - saturating back-pressure counter
- Sits between the data-memory stage and the register-file write port.

---
 rtl/memwb_pipe_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/memwb_pipe_stage.sv
// ============================================================================
// Module   : memwb_pipe_stage
// Brief    : MEM/WB pipeline stage. It has a valid/ready handshake on both
//            sides, a 2-entry skid buffer, a synchronous flush, the writeback
//            mux, x0 write gating and a saturating back-pressure counter.
//            Optional EX forwarding ports are added when MEMWB_STAGE_FWD_EN
//            is defined.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module memwb_pipe_stage #(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   start_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   RegWrite_i,
  input  logic                   MemtoReg_i,
  input  logic [DATA_W-1:0]      ALUdata_i,
  input  logic [DATA_W-1:0]      ReadData_i,
  input  logic [RADDR_W-1:0]     RegWaddr_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   RegWrite_o,
  output logic [DATA_W-1:0]      WbData_o,
  output logic [RADDR_W-1:0]     RegWaddr_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`ifdef MEMWB_STAGE_FWD_EN
  ,
  output logic                   fwd_valid_o,
  output logic [RADDR_W-1:0]     fwd_addr_o,
  output logic [DATA_W-1:0]      fwd_data_o
`endif
);

  localparam logic [STALL_CNT_W-1:0] C_CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] C_CNT_MAX = {STALL_CNT_W{1'b1}};

  logic                   out_valid_q, out_valid_d;
  logic                   out_rw_q,    out_rw_d;
  logic [DATA_W-1:0]      out_data_q,  out_data_d;
  logic [RADDR_W-1:0]     out_addr_q,  out_addr_d;
  logic                   skd_valid_q, skd_valid_d;
  logic                   skd_rw_q,    skd_rw_d;
  logic [DATA_W-1:0]      skd_data_q,  skd_data_d;
  logic [RADDR_W-1:0]     skd_addr_q,  skd_addr_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic              w_accept;
  logic              w_consume;
  logic [DATA_W-1:0] w_in_data;

  assign ready_o   = !skd_valid_q;
  assign w_accept  = valid_i && ready_o;
  assign w_consume = out_valid_q && ready_i;
  // Writeback data is selected when the entry is captured, so downstream sees a settled value.
  assign w_in_data = MemtoReg_i ? ReadData_i : ALUdata_i;

  always_comb begin
    out_valid_d = out_valid_q;
    out_rw_d    = out_rw_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    skd_valid_d = skd_valid_q;
    skd_rw_d    = skd_rw_q;
    skd_data_d  = skd_data_q;
    skd_addr_d  = skd_addr_q;

    if (flush_i) begin
      out_valid_d = 1'b0;
      skd_valid_d = 1'b0;
    end else if (!out_valid_q || w_consume) begin
      if (skd_valid_q) begin
        out_valid_d = 1'b1;
        out_rw_d    = skd_rw_q;
        out_data_d  = skd_data_q;
        out_addr_d  = skd_addr_q;
        skd_valid_d = w_accept;
        if (w_accept) begin
          skd_rw_d   = RegWrite_i;
          skd_data_d = w_in_data;
          skd_addr_d = RegWaddr_i;
        end
      end else begin
        out_valid_d = w_accept;
        if (w_accept) begin
          out_rw_d   = RegWrite_i;
          out_data_d = w_in_data;
          out_addr_d = RegWaddr_i;
        end
      end
    end else if (w_accept) begin
      skd_valid_d = 1'b1;
      skd_rw_d    = RegWrite_i;
      skd_data_d  = w_in_data;
      skd_addr_d  = RegWaddr_i;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !ready_i && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      out_valid_q <= 1'b0;
      out_rw_q    <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      skd_valid_q <= 1'b0;
      skd_rw_q    <= 1'b0;
      skd_data_q  <= '0;
      skd_addr_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rw_q    <= out_rw_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      skd_valid_q <= skd_valid_d;
      skd_rw_q    <= skd_rw_d;
      skd_data_q  <= skd_data_d;
      skd_addr_q  <= skd_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_o     = out_valid_q;
  assign RegWrite_o  = out_valid_q && out_rw_q && (out_addr_q != '0);
  assign WbData_o    = out_data_q;
  assign RegWaddr_o  = out_addr_q;
  assign stall_cnt_o = stall_cnt_q;

`ifdef MEMWB_STAGE_FWD_EN
  // Only the OUT entry is forwarded; a younger SKD entry is deliberately hidden.
  assign fwd_valid_o = RegWrite_o;
  assign fwd_addr_o  = out_addr_q;
  assign fwd_data_o  = out_data_q;
`endif

endmodule

`default_nettype wire
